amiq_dvcon_blue_rx: RTL and testbench

- Consumer side of the blue push bus (field0/field1/field2 + valid, no backpressure).
- Captures every beat where valid is high into a first-word-fall-through FIFO.
- Re-presents buffered beats on a valid/ready output stream for the downstream DUT logic.
- Because the input side cannot be stalled, it counts beats dropped on overflow and raises a sticky overflow flag.

---
 rtl/amiq_dvcon_blue_rx.sv | 100 ++++++++++
 tb/tb_amiq_dvcon_blue_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/amiq_dvcon_blue_rx.sv
// ==== amiq_dvcon_blue_rx : blue push-bus receiver, FWFT FIFO with drop counter ==== rev 1.0
`default_nettype none

module amiq_dvcon_blue_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              field0,
  input  logic [31:0]              field1,
  input  logic [31:0]              field2,
  input  logic                     valid,
  output logic [31:0]              out_field0,
  output logic [31:0]              out_field1,
  output logic [31:0]              out_field2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [95:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic             w_nempty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [95:0]      w_head;

  assign w_nempty = (level_q != '0);
  assign w_full   = (level_q == FULL_LVL);
  assign w_pop    = w_nempty & out_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push   = valid & (~w_full | w_pop);
  assign w_drop   = valid & w_full & ~w_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (!w_push && w_pop) begin
      level_d = level_q - 1'b1;
    end
    if (w_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; the level gates what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[wr_ptr_q] <= {field2, field1, field0};
  end

  assign w_head     = mem_q[rd_ptr_q];
  assign out_valid  = w_nempty;
  assign out_field0 = w_nempty ? w_head[31:0]  : 32'd0;
  assign out_field1 = w_nempty ? w_head[63:32] : 32'd0;
  assign out_field2 = w_nempty ? w_head[95:64] : 32'd0;
  assign level      = level_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_amiq_dvcon_blue_rx.sv
// ==== tb_amiq_dvcon_blue_rx : directed bench with queue-based reference model ==== rev 1.0
`default_nettype none

module tb_amiq_dvcon_blue_rx;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       field0, field1, field2;
  logic              valid;
  logic [31:0]       out_field0, out_field1, out_field2;
  logic              out_valid;
  logic              out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]  drop_cnt;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [95:0] mq[$];
  int          m_drops = 0;
  bit          m_ovf   = 1'b0;
  int          m_n;
  bit          m_pop;

  always #5 clk = ~clk;

  amiq_dvcon_blue_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .field0     (field0),
    .field1     (field1),
    .field2     (field2),
    .valid      (valid),
    .out_field0 (out_field0),
    .out_field1 (out_field1),
    .out_field2 (out_field2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an occupancy-limited queue plus a saturating drop tally.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      m_n   = mq.size();
      m_pop = (m_n != 0) && (out_ready === 1'b1);
      if (m_pop) void'(mq.pop_front());
      if (valid === 1'b1) begin
        if (m_n < DEPTH || m_pop) begin
          mq.push_back({field2, field1, field0});
        end else begin
          if (m_drops < SAT_MAX) m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
      chk("m_f0", out_field0, (mq.size() != 0) ? mq[0][31:0]  : 32'd0);
      chk("m_f1", out_field1, (mq.size() != 0) ? mq[0][63:32] : 32'd0);
      chk("m_f2", out_field2, (mq.size() != 0) ? mq[0][95:64] : 32'd0);
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_drop", 32'(drop_cnt), 32'(m_drops));
      chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic drive3(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic rdy);
    valid     = v;
    field0    = v ? a : 'x;
    field1    = v ? b : 'x;
    field2    = v ? c : 'x;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic rdy);
    drive3(v, a, a ^ 32'h5A5A_5A5A, ~a, rdy);
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 32'd0, 1'b0);
    drv(1'b0, 32'd0, 1'b0);
    chk_en = 1'b1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // single beat, then pop
    drive3(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0);
    chk("sb_valid", {31'd0, out_valid}, 32'd1);
    chk("sb_f0", out_field0, 32'h1111_1111);
    chk("sb_f1", out_field1, 32'h2222_2222);
    chk("sb_f2", out_field2, 32'h3333_3333);
    chk("sb_level", 32'(level), 32'd1);
    drv(1'b0, 32'd0, 1'b1);
    chk("sb_pop_valid", {31'd0, out_valid}, 32'd0);
    chk("sb_pop_f0", out_field0, 32'd0);
    chk("sb_pop_level", 32'(level), 32'd0);

    // fill past capacity
    for (int i = 1; i <= 6; i++) drv(1'b1, 32'(i), 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", out_field0, 32'(i));
      drv(1'b0, 32'd0, 1'b1);
    end
    chk("ovf_empty", {31'd0, out_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) drv(1'b1, 32'(i), 1'b0);
    drv(1'b1, 32'd5, 1'b1);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 2; i <= 5; i++) begin
      chk("pp_drain", out_field0, 32'(i));
      drv(1'b0, 32'd0, 1'b1);
    end

    // back-to-back streaming
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 32'(i), 1'b1);
      chk("st_head", out_field0, 32'(i));
      chk("st_level", 32'(level), 32'd1);
    end
    drv(1'b0, 32'd0, 1'b1);
    chk("st_level_end", 32'(level), 32'd0);
    chk("st_drop", 32'(drop_cnt), 32'd2);

    // saturation of the drop counter
    for (int i = 0; i < 4; i++) drv(1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 20; i++) drv(1'b1, 32'(200 + i), 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'd15);
    chk("sat_head", out_field0, 32'd100);

    // reset mid-operation
    rst = 1'b1;
    drv(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) drv(1'b1, 32'(300 + i), 1'b0);
    drv(1'b0, 32'd0, 1'b1);
    chk("mr_level_pre", 32'(level), 32'd3);
    chk("mr_drop_pre", 32'(drop_cnt), 32'd5);
    rst = 1'b1;
    drv(1'b1, 32'hDEAD, 1'b0);
    rst = 1'b0;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_drop", 32'(drop_cnt), 32'd0);
    chk("mr_ovf", {31'd0, overflow}, 32'd0);
    drv(1'b1, 32'h77, 1'b0);
    chk("mr_first", out_field0, 32'h77);
    chk("mr_first_lvl", 32'(level), 32'd1);
    drv(1'b0, 32'd0, 1'b1);
    chk("mr_drained", 32'(level), 32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
